// File: rtl/fetch.sv
// fetch: RISC-V instruction-fetch stage; owns the PC, drives the imem request/valid handshake
// and loads the fetch->decode register (InstrB/PCB/PCPlus4B/ValidB).
module fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallB,
  input  logic                  RedirectE,
  input  logic [DATA_WIDTH-1:0] RedirectPCE,
  output logic                  ImemReqA,
  output logic [DATA_WIDTH-1:0] ImemAddrA,
  input  logic                  ImemRdyA,
  input  logic                  ImemValidA,
  input  logic [31:0]           ImemDataA,
  output logic [31:0]           InstrB,
  output logic [DATA_WIDTH-1:0] PCB,
  output logic [DATA_WIDTH-1:0] PCPlus4B,
  output logic                  ValidB
);
  localparam logic [31:0]           NOP  = 32'h0000_0013;
  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;
  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_pc, r_req_pc, r_skid_pc, w_b_pc;
  logic [31:0]           r_skid, w_b_instr;
  logic                  w_redir, w_deliver, w_capture, w_unskid, w_accept, w_load_b, w_b_valid;
  always_comb begin
    w_redir   = RedirectE && r_state != IDLE;
    w_deliver = r_state == WAIT && ImemValidA && !StallB;
    w_capture = r_state == WAIT && ImemValidA && StallB && !w_redir;
    w_unskid  = r_state == HOLD && !StallB && !w_redir;
    ImemReqA  = !rst && !RedirectE && (r_state == REQ || w_deliver);
    ImemAddrA = rst ? RESET_PC : r_pc;
    w_accept  = ImemReqA && ImemRdyA;
    w_load_b  = w_redir || (!StallB && r_state != IDLE);
    w_b_valid = !w_redir && (w_deliver || w_unskid);
    w_b_instr = w_unskid ? r_skid : ImemDataA;
    w_b_pc    = w_unskid ? r_skid_pc : r_req_pc;
    // an outstanding response that a redirect orphans must still be drained in DROP
    w_next = w_redir ? (((r_state == WAIT || r_state == DROP) && !ImemValidA) ? DROP : REQ)
           : r_state == IDLE ? REQ
           : r_state == REQ  ? (w_accept ? WAIT : REQ)
           : r_state == WAIT ? (!ImemValidA ? WAIT : StallB ? HOLD : w_accept ? WAIT : REQ)
           : r_state == HOLD ? (StallB ? HOLD : REQ)
           : (ImemValidA ? REQ : DROP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_req_pc  <= '0;
      r_skid    <= '0;
      r_skid_pc <= '0;
      InstrB    <= NOP;
      PCB       <= '0;
      PCPlus4B  <= '0;
      ValidB    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_redir) r_pc <= RedirectPCE & ~DATA_WIDTH'(3);
      else if (w_accept) begin
        r_pc     <= r_pc + FOUR;
        r_req_pc <= r_pc;
      end
      if (w_capture) begin
        r_skid    <= ImemDataA;
        r_skid_pc <= r_req_pc;
      end
      if (w_load_b) begin
        ValidB   <= w_b_valid;
        InstrB   <= w_b_valid ? w_b_instr : NOP;
        PCB      <= w_b_valid ? w_b_pc : '0;
        PCPlus4B <= w_b_valid ? w_b_pc + FOUR : '0;
      end
    end
  end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed + randomized bench; a program-order fetch model with a latency-driven
// instruction memory predicts requests and the fetch->decode register every cycle.
module tb_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 0, rst = 1, StallB = 0, RedirectE = 0, ImemRdyA = 0, ImemValidA = 0;
  logic [31:0] RedirectPCE = '0, ImemDataA = '0;
  logic        ImemReqA, ValidB;
  logic [31:0] ImemAddrA, InstrB, PCB, PCPlus4B;
  int          checks = 0, errors = 0;
  logic        pend = 0, pend_stale = 0, skid = 0, m_valid = 0, s_req = 0;
  logic [31:0] pend_addr = '0, skid_addr = '0, exp_req = '0, m_instr = NOP, m_pc = '0, s_addr = '0;
  int          pend_due = 0, cyc = 0, lat = 1, delivered = 0;
  bit          seen;

  always #5 clk = ~clk;

  fetch #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .StallB(StallB), .RedirectE(RedirectE), .RedirectPCE(RedirectPCE),
    .ImemReqA(ImemReqA), .ImemAddrA(ImemAddrA), .ImemRdyA(ImemRdyA), .ImemValidA(ImemValidA),
    .ImemDataA(ImemDataA), .InstrB(InstrB), .PCB(PCB), .PCPlus4B(PCPlus4B), .ValidB(ValidB)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0093;
  endfunction

  // one clock cycle: drive inputs, check the request side, predict and check B after the edge
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
    logic resp, live, busy;
    if (cyc <= 1) rd = 1'b0;
    StallB = st; RedirectE = rd; RedirectPCE = rpc; ImemRdyA = rdy;
    resp = !rst && pend && cyc >= pend_due;
    ImemValidA = resp;
    ImemDataA = resp ? imem(pend_addr) : $urandom;
    #2;
    s_req = ImemReqA; s_addr = ImemAddrA;
    if (rst) begin
      check("rst_req", 32'(s_req), 32'd0);
      check("rst_addr", s_addr, 32'd0);
      pend = 0; skid = 0; exp_req = '0;
      m_valid = 0; m_instr = NOP; m_pc = '0;
    end else begin
      busy = (pend && !resp) || (resp && (st || pend_stale)) || skid || rd || cyc == 1;
      check("req", 32'(s_req), 32'(!busy));
      if (s_req) check("req_addr", s_addr, exp_req);
      live = resp && !pend_stale && !rd;
      if (resp) pend = 0;
      if (rd) begin
        if (pend) pend_stale = 1;
        skid = 0; exp_req = rpc & ~32'h3;
        m_valid = 0; m_instr = NOP; m_pc = '0;
      end else if (st) begin
        if (live) begin skid = 1; skid_addr = pend_addr; end
      end else if (live || skid) begin
        m_pc = live ? pend_addr : skid_addr;
        m_valid = 1; m_instr = imem(m_pc); skid = 0; delivered++;
      end else begin
        m_valid = 0; m_instr = NOP; m_pc = '0;
      end
      if (s_req && rdy) begin
        pend = 1; pend_stale = 0; pend_addr = exp_req; pend_due = cyc + lat;
        exp_req = exp_req + 32'd4;
      end
    end
    @(posedge clk); #1;
    cyc = rst ? 1 : cyc + 1;
    check("b_valid", 32'(ValidB), 32'(m_valid));
    check("b_instr", InstrB, m_instr);
    check("b_pc", PCB, m_pc);
    check("b_pc4", PCPlus4B, m_valid ? m_pc + 32'd4 : 32'd0);
  endtask

  initial begin
    @(posedge clk); #1;
    rst = 1; step(0, 0, 0, 1); step(0, 0, 0, 1);
    rst = 0; lat = 1;
    step(0, 0, 0, 1);
    check("idle_req", 32'(s_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      check("stream_req", 32'(s_req), 32'd1);
      check("stream_addr", s_addr, 32'(i * 4));
      if (i > 0) check("stream_pcb", PCB, 32'((i - 1) * 4));
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1);
      check("stall_hold", PCB, 32'd4);
    end
    step(0, 0, 0, 1);
    check("unskid_pcb", PCB, 32'd8);
    lat = 3;
    step(0, 0, 0, 1);
    check("resume_addr", s_addr, 32'd12);
    step(0, 1, 32'h103, 1);
    check("redir_bubble", 32'(ValidB), 32'd0);
    lat = 1; seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step(0, 0, 0, 1);
      if (s_req) begin seen = 1; check("redir_addr", s_addr, 32'h100); end
    end
    check("redir_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      check("bp_req", 32'(s_req), 32'd1);
      check("bp_addr", s_addr, 32'h104);
      if (i > 0) check("bp_bubble", 32'(ValidB), 32'd0);
    end
    step(0, 0, 0, 1);
    step(0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 1);
    check("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    check("wrap_addr1", s_addr, 32'h0);
    check("wrap_pc4", PCPlus4B, 32'h0);
    lat = 3;
    step(0, 0, 0, 1);
    rst = 1; step(0, 0, 0, 1);
    check("rst_bubble", InstrB, NOP);
    rst = 0;
    step(0, 0, 0, 1);
    check("rst_idle", 32'(s_req), 32'd0);
    step(0, 0, 0, 1);
    check("rst_first_addr", s_addr, 32'd0);
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 3);
      rst = ($urandom_range(0, 499) == 0);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0);
    end
    check("progress", 32'(delivered > 300), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
